imm_extend_arbiter: RTL and testbench

Shared immediate-extension unit for the RISC datapath: arbitrates between two immediate consumers, requester A (ALU immediate operand) and requester B (branch/jump offset path), and extends the granted 16-bit immediate to 32 bits. The extension mode is selected per request. Results are held in a one-entry output register with a valid/ready handshake. It sits between decode and the ALU/PC-update logic, so a single extender serves both paths.

---
 rtl/imm_extend_arbiter.sv | 88 ++++++++
 tb/tb_imm_extend_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_arbiter.sv
// Shared immediate extender: round-robin arbitration between two requesters,
// one-entry output register with a valid/ready handshake.
module imm_extend_arbiter #(
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_imm,
  input  logic [1:0]  a_mode,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [15:0] b_imm,
  input  logic [1:0]  b_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [31:0] data_nxt;
  logic        src_nxt;
  logic        can_load;
  logic        grant_b;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] sext;
    sext = {{16{imm[15]}}, imm};
    case (mode)
      2'b00:   extend_imm = sext;
      2'b01:   extend_imm = {16'h0000, imm};
      2'b10:   extend_imm = sext << BR_SHIFT;
      default: extend_imm = {imm, 16'h0000};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= SRC_B;
      out_data   <= 32'h0;
      out_src    <= SRC_A;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      out_data   <= data_nxt;
      out_src    <= src_nxt;
    end
  end

  // B wins only when A is idle or A was the last one served.
  always_comb begin
    can_load       = (state == EMPTY) || out_ready;
    grant_b        = b_valid && (!a_valid || (last_grant == SRC_A));
    a_ready        = rst_n && can_load && a_valid && !grant_b;
    b_ready        = rst_n && can_load && grant_b;
    out_valid      = (state == FULL);
    state_nxt      = state;
    last_grant_nxt = last_grant;
    data_nxt       = out_data;
    src_nxt        = out_src;
    if (a_ready) begin
      data_nxt       = extend_imm(a_imm, a_mode);
      src_nxt        = SRC_A;
      state_nxt      = FULL;
      last_grant_nxt = SRC_A;
    end else if (b_ready) begin
      data_nxt       = extend_imm(b_imm, b_mode);
      src_nxt        = SRC_B;
      state_nxt      = FULL;
      last_grant_nxt = SRC_B;
    end else if ((state == FULL) && out_ready) begin
      state_nxt = EMPTY;
    end
  end

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Scoreboard bench for imm_extend_arbiter: directed rows push expected results,
// a negedge monitor pops and compares each result the consumer takes.
module tb_imm_extend_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_imm;
  logic [1:0]  a_mode;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_imm;
  logic [1:0]  b_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;

  int total = 0;
  int bad = 0;
  logic [32:0] sb[$];

  imm_extend_arbiter #(.BR_SHIFT(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_imm(a_imm),
    .a_mode(a_mode),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_imm(b_imm),
    .b_mode(b_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive, check readies/out_valid at negedge, queue expected result.
  task automatic applyStimulus(input string name,
                               input logic av, input logic [15:0] aimm, input logic [1:0] amode,
                               input logic bv, input logic [15:0] bimm, input logic [1:0] bmode,
                               input logic ordy, input logic exp_ar, input logic exp_br,
                               input logic [31:0] exp_data, input int exp_ov);
    a_valid   = av;
    a_imm     = aimm;
    a_mode    = amode;
    b_valid   = bv;
    b_imm     = bimm;
    b_mode    = bmode;
    out_ready = ordy;
    @(negedge clk);
    checkOutput({name, "_rdy"}, {31'b0, a_ready, b_ready}, {31'b0, exp_ar, exp_br});
    if (exp_ov >= 0)
      checkOutput({name, "_ov"}, {32'b0, out_valid}, 33'(exp_ov));
    if (exp_ar || exp_br)
      sb.push_back({exp_br, exp_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input int exp_ov);
    applyStimulus(name, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, exp_ov);
  endtask

  // Monitor: every result actually taken by the consumer must match the queue head.
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got src=%0d data=%h expected none", out_src, out_data);
        end else begin
          exp = sb.pop_front();
          checkOutput("result", {out_src, out_data}, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_imm     = 16'h0011;
    a_mode    = 2'b01;
    b_imm     = 16'h0022;
    b_mode    = 2'b01;
    out_ready = 1'b1;

    // Reset with both requesters active
    repeat (2) @(negedge clk);
    checkOutput("rst_ov",    {32'b0, out_valid}, 33'd0);
    checkOutput("rst_data",  {1'b0, out_data},   33'h0);
    checkOutput("rst_src",   {32'b0, out_src},   33'd0);
    checkOutput("rst_ready", {31'b0, a_ready, b_ready}, 33'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin from reset: A, B, A, B every cycle
    applyStimulus("rr0", 1, 16'h0011, 2'b01, 1, 16'h0022, 2'b01, 1, 1, 0, 32'h00000011, 0);
    applyStimulus("rr1", 1, 16'h0011, 2'b01, 1, 16'h0022, 2'b01, 1, 0, 1, 32'h00000022, 1);
    applyStimulus("rr2", 1, 16'h0011, 2'b01, 1, 16'h0022, 2'b01, 1, 1, 0, 32'h00000011, 1);
    applyStimulus("rr3", 1, 16'h0011, 2'b01, 1, 16'h0022, 2'b01, 1, 0, 1, 32'h00000022, 1);
    idle("rr_idle0", 1);
    idle("rr_idle1", 0);

    // Extension modes through A
    applyStimulus("m00",   1, 16'h8001, 2'b00, 0, 16'h0, 2'b00, 1, 1, 0, 32'hFFFF8001, 0);
    applyStimulus("m01",   1, 16'h8001, 2'b01, 0, 16'h0, 2'b00, 1, 1, 0, 32'h00008001, 1);
    applyStimulus("m10n",  1, 16'hFFFF, 2'b10, 0, 16'h0, 2'b00, 1, 1, 0, 32'hFFFFFFFC, 1);
    applyStimulus("m10p",  1, 16'h4000, 2'b10, 0, 16'h0, 2'b00, 1, 1, 0, 32'h00010000, 1);
    applyStimulus("m11",   1, 16'h1234, 2'b11, 0, 16'h0, 2'b00, 1, 1, 0, 32'h12340000, 1);
    idle("m_idle0", 1);
    idle("m_idle1", 0);

    // Backpressure: B result held while A waits, then drain and accept on one edge
    applyStimulus("bp_b", 0, 16'h0, 2'b00, 1, 16'h0005, 2'b00, 0, 0, 1, 32'h00000005, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("bp_hold", 1, 16'h0007, 2'b01, 0, 16'h0, 2'b00, 0, 0, 0, 32'h0, 1);
      checkOutput("bp_data", {1'b0, out_data}, 33'h00000005);
    end
    applyStimulus("bp_rel", 1, 16'h0007, 2'b01, 0, 16'h0, 2'b00, 1, 1, 0, 32'h00000007, 1);
    idle("bp_idle0", 1);
    idle("bp_idle1", 0);

    // Single requester burst, then A joins and wins the tie
    applyStimulus("sb0", 0, 16'h0, 2'b00, 1, 16'h0100, 2'b11, 1, 0, 1, 32'h01000000, 0);
    applyStimulus("sb1", 0, 16'h0, 2'b00, 1, 16'h0200, 2'b11, 1, 0, 1, 32'h02000000, 1);
    applyStimulus("sb2", 0, 16'h0, 2'b00, 1, 16'h0300, 2'b00, 1, 0, 1, 32'h00000300, 1);
    applyStimulus("sb3", 0, 16'h0, 2'b00, 1, 16'h0400, 2'b01, 1, 0, 1, 32'h00000400, 1);
    applyStimulus("sb_tie", 1, 16'h0009, 2'b00, 1, 16'h0500, 2'b00, 1, 1, 0, 32'h00000009, 1);
    applyStimulus("sb_b",   0, 16'h0,    2'b00, 1, 16'h0500, 2'b00, 1, 0, 1, 32'h00000500, 1);
    idle("sb_idle0", 1);
    idle("sb_idle1", 0);

    // Reset mid-burst: the pending result is discarded, tie then goes to A
    applyStimulus("rb_acc", 1, 16'h0AAA, 2'b01, 0, 16'h0, 2'b00, 1, 1, 0, 32'h00000AAA, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rb_async_ov",   {32'b0, out_valid}, 33'd0);
    checkOutput("rb_async_data", {1'b0, out_data},   33'h0);
    sb.delete();
    a_valid = 1'b1;
    a_imm   = 16'h0033;
    a_mode  = 2'b00;
    b_valid = 1'b1;
    b_imm   = 16'h0044;
    b_mode  = 2'b00;
    @(negedge clk);
    checkOutput("rb_ready", {31'b0, a_ready, b_ready}, 33'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("rb_tie", 1, 16'h0033, 2'b00, 1, 16'h0044, 2'b00, 1, 1, 0, 32'h00000033, 0);
    applyStimulus("rb_b",   0, 16'h0,    2'b00, 1, 16'h0044, 2'b00, 1, 0, 1, 32'h00000044, 1);
    idle("rb_idle0", 1);
    idle("rb_idle1", 0);

    checkOutput("sb_empty", 33'(sb.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
